move_request_decoder: RTL and testbench

Front-end stage of the board validator. Accepts a move request (old/new square) over a valid/ready handshake and reads the moving piece and the target square from the board. Computes absolute deltas, runs generic legality pre-checks, then dispatches to the per-piece checker (bishop, rook, …) and returns a single legal/illegal response with an error code.

---
 rtl/chess_pkg.sv | 53 +++++
 rtl/move_precheck.sv | 62 ++++++
 rtl/move_request_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_move_request_decoder.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared definitions for the board validator front end.
//   piece_t      4-bit square code: [2:0] kind, [3] colour (1 = black)
//   kind_t       piece kind constants EMPTY, PAWN .. KING, KIND_BAD
//   COLOUR_BIT   index of the colour bit inside piece_t
//   resp_err_t   response error codes
//   dec_state_t  move_request_decoder FSM states
package chess_pkg;

  typedef logic [3:0] piece_t;
  typedef logic [2:0] kind_t;

  localparam piece_t PIECE_EMPTY = 4'h0;

  localparam kind_t EMPTY    = 3'd0;
  localparam kind_t PAWN     = 3'd1;
  localparam kind_t KNIGHT   = 3'd2;
  localparam kind_t BISHOP   = 3'd3;
  localparam kind_t ROOK     = 3'd4;
  localparam kind_t QUEEN    = 3'd5;
  localparam kind_t KING     = 3'd6;
  localparam kind_t KIND_BAD = 3'd7;

  localparam int unsigned COLOUR_BIT   = 3;
  localparam int unsigned NUM_CHECKERS = 6;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SRC     = 2'd1,
    ERR_DST     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } resp_err_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_DISPATCH,
    ST_WAIT,
    ST_RESP
  } dec_state_t;

  function automatic kind_t piece_kind(input piece_t p);
    return p[2:0];
  endfunction

  function automatic logic piece_colour(input piece_t p);
    return p[COLOUR_BIT];
  endfunction

  function automatic logic [2:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/move_precheck.sv
// Generic legality pre-checks for one move request (purely combinational).
// Ports:
//   src, dst                    piece codes on the source / destination squares
//   old_x, old_y, new_x, new_y  move coordinates
//   side_to_move                0 = white, 1 = black
//   h_delta, v_delta            |new_x-old_x|, |new_y-old_y|
//   err                         0 none, 1 bad source, 2 bad destination / null move
//   sel                         one-hot checker select (bit0 pawn .. bit5 king)
module move_precheck
  import chess_pkg::*;
(
  input  logic [3:0] src,
  input  logic [3:0] dst,
  input  logic [2:0] old_x,
  input  logic [2:0] old_y,
  input  logic [2:0] new_x,
  input  logic [2:0] new_y,
  input  logic       side_to_move,
  output logic [2:0] h_delta,
  output logic [2:0] v_delta,
  output logic [1:0] err,
  output logic [5:0] sel
);

  kind_t     kind;
  logic      src_bad;
  logic      dst_bad;
  resp_err_t code;

  always_comb begin
    kind = piece_kind(src);

    sel = '0;
    case (kind)
      PAWN:    sel = 6'b000001;
      KNIGHT:  sel = 6'b000010;
      BISHOP:  sel = 6'b000100;
      ROOK:    sel = 6'b001000;
      QUEEN:   sel = 6'b010000;
      KING:    sel = 6'b100000;
      default: sel = '0;
    endcase

    src_bad = (src == PIECE_EMPTY) || (kind == EMPTY) || (kind == KIND_BAD) ||
              (piece_colour(src) != side_to_move);

    dst_bad = ((old_x == new_x) && (old_y == new_y)) ||
              ((dst != PIECE_EMPTY) && (piece_colour(dst) == piece_colour(src)));

    code = ERR_NONE;
    if (src_bad) begin
      code = ERR_SRC;
    end else if (dst_bad) begin
      code = ERR_DST;
    end
  end

  assign err     = code;
  assign h_delta = abs_diff(new_x, old_x);
  assign v_delta = abs_diff(new_y, old_y);

endmodule

// File: rtl/move_request_decoder.sv
// Front end of the board validator: accepts a move request, reads source and
// destination squares, runs generic pre-checks, dispatches to the per-piece
// checker and returns one legal/illegal response with an error code.
// Optional feature: define DECODER_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYCLES cycles (response err 3 on expiry).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid / req_ready      request handshake
//   old_x, old_y, new_x, new_y move squares, sampled on handshake
//   side_to_move               0 = white, 1 = black, sampled on handshake
//   board_in                   board, board_in[y][x] 4-bit piece code
//   h_delta, v_delta           absolute deltas for the checkers
//   piece_type                 latched source-square code
//   chk_start, chk_sel         checker start pulse and one-hot select
//   chk_valid_move/output      per-checker result and result-valid
//   resp_valid / resp_ready    response handshake
//   resp_legal, resp_err       response payload
module move_request_decoder
  import chess_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            old_x,
  input  logic [2:0]            old_y,
  input  logic [2:0]            new_x,
  input  logic [2:0]            new_y,
  input  logic                  side_to_move,
  input  logic [7:0][7:0][3:0]  board_in,
  output logic [2:0]            h_delta,
  output logic [2:0]            v_delta,
  output logic [3:0]            piece_type,
  output logic                  chk_start,
  output logic [5:0]            chk_sel,
  input  logic [5:0]            chk_valid_move,
  input  logic [5:0]            chk_valid_output,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_legal,
  output logic [1:0]            resp_err
);

  dec_state_t state_q, state_d;

  logic [2:0]              old_x_q, old_y_q, new_x_q, new_y_q;
  logic                    side_q;
  logic [NUM_CHECKERS-1:0] sel_q;
  piece_t                  piece_q;
  logic [2:0]              hd_q, vd_q;
  logic                    legal_q;
  resp_err_t               err_q;

  piece_t     src, dst;
  logic [2:0] pc_hd, pc_vd;
  logic [1:0] pc_err;
  logic [5:0] pc_sel;
  logic       hit_valid, hit_legal;
  logic       timeout_hit;

  assign src = board_in[old_y_q][old_x_q];
  assign dst = board_in[new_y_q][new_x_q];

  move_precheck u_precheck (
    .src          (src),
    .dst          (dst),
    .old_x        (old_x_q),
    .old_y        (old_y_q),
    .new_x        (new_x_q),
    .new_y        (new_y_q),
    .side_to_move (side_q),
    .h_delta      (pc_hd),
    .v_delta      (pc_vd),
    .err          (pc_err),
    .sel          (pc_sel)
  );

  // Only the selected checker's bits matter; sel_q is one-hot.
  assign hit_valid = |(chk_valid_output & sel_q);
  assign hit_legal = |(chk_valid_move & sel_q);

`ifdef DECODER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q;

  // Counts completed WAIT cycles; the limit fires during the last allowed cycle
  // so that a result arriving in that same cycle still takes priority.
  assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_DISPATCH) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    chk_start  = 1'b0;
    chk_sel    = '0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = (pc_err != ERR_NONE) ? ST_RESP : ST_DISPATCH;
      end
      ST_DISPATCH: begin
        chk_start = 1'b1;
        chk_sel   = sel_q;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        chk_sel = sel_q;
        if (hit_valid || timeout_hit) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      old_x_q <= '0;
      old_y_q <= '0;
      new_x_q <= '0;
      new_y_q <= '0;
      side_q  <= 1'b0;
      sel_q   <= '0;
      piece_q <= PIECE_EMPTY;
      hd_q    <= '0;
      vd_q    <= '0;
      legal_q <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            old_x_q <= old_x;
            old_y_q <= old_y;
            new_x_q <= new_x;
            new_y_q <= new_y;
            side_q  <= side_to_move;
          end
        end
        ST_DECODE: begin
          piece_q <= src;
          hd_q    <= pc_hd;
          vd_q    <= pc_vd;
          sel_q   <= pc_sel;
          if (pc_err != ERR_NONE) begin
            legal_q <= 1'b0;
            err_q   <= resp_err_t'(pc_err);
          end
        end
        ST_WAIT: begin
          if (hit_valid) begin
            legal_q <= hit_legal;
            err_q   <= ERR_NONE;
          end else if (timeout_hit) begin
            legal_q <= 1'b0;
            err_q   <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign h_delta    = hd_q;
  assign v_delta    = vd_q;
  assign piece_type = piece_q;
  assign resp_legal = legal_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_move_request_decoder.sv
// Self-checking bench for move_request_decoder. A transaction-level model
// predicts, per cycle, the handshake/dispatch/response outputs from the
// acceptance cycle, the pre-check rules and the checker latency the bench
// itself chooses. Define DECODER_TIMEOUT_EN for both bench and RTL to cover
// the timeout build.
`timescale 1ns/1ps
module tb_move_request_decoder;

  localparam int TO_N = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           old_x, old_y, new_x, new_y;
  logic                 side_to_move;
  logic [7:0][7:0][3:0] board_in;
  logic [2:0]           h_delta, v_delta;
  logic [3:0]           piece_type;
  logic                 chk_start;
  logic [5:0]           chk_sel;
  logic [5:0]           chk_valid_move;
  logic [5:0]           chk_valid_output;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 resp_legal;
  logic [1:0]           resp_err;

  move_request_decoder #(.TIMEOUT_CYCLES(TO_N)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .old_x            (old_x),
    .old_y            (old_y),
    .new_x            (new_x),
    .new_y            (new_y),
    .side_to_move     (side_to_move),
    .board_in         (board_in),
    .h_delta          (h_delta),
    .v_delta          (v_delta),
    .piece_type       (piece_type),
    .chk_start        (chk_start),
    .chk_sel          (chk_sel),
    .chk_valid_move   (chk_valid_move),
    .chk_valid_output (chk_valid_output),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_legal       (resp_legal),
    .resp_err         (resp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // transaction model
  bit   active;
  bit   m_ok;
  int   t_acc, t_resp, m_lat, m_kind, m_piece, m_hd, m_vd, m_err, m_legal, m_chk_legal;
  logic [5:0] m_sel;

  // per-cycle expectations
  bit   exp_ready, exp_start, exp_rv, cmp_dp, cmp_resp;
  logic [5:0] exp_sel;
  int   exp_piece, exp_hd, exp_vd, exp_legal, exp_err;

  // stimulus policy
  int force_lat   = -1;
  int force_legal = -1;
  int rr_delay    = 0;
  bit scramble_en = 1'b0;

  // observations of the DUT for literal pins
  int cap_start, cap_sel, cap_hd, cap_vd, cap_resp, cap_legal, cap_err, cap_rv_len, n_starts;
  bit cap_rv_seen;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    active    = 1'b0;
    cmp_dp    = 1'b1;
    exp_piece = 0; exp_hd = 0; exp_vd = 0;
    cmp_resp  = 1'b1;
    exp_legal = 0; exp_err = 0;
  endtask

  task automatic accept(input int t);
    int src, dst, w;
    src    = int'(board_in[old_y][old_x]);
    dst    = int'(board_in[new_y][new_x]);
    m_kind = src % 8;
    m_piece = src;
    m_hd   = (old_x > new_x) ? int'(old_x) - int'(new_x) : int'(new_x) - int'(old_x);
    m_vd   = (old_y > new_y) ? int'(old_y) - int'(new_y) : int'(new_y) - int'(old_y);
    if (src == 0 || m_kind == 0 || m_kind == 7 || (src / 8) != int'(side_to_move))
      m_err = 1;
    else if ((old_x == new_x && old_y == new_y) || (dst != 0 && (dst / 8) == (src / 8)))
      m_err = 2;
    else
      m_err = 0;
    m_ok  = (m_err == 0);
    m_sel = m_ok ? 6'(1 << (m_kind - 1)) : 6'd0;
    t_acc = t;
    if (m_ok) begin
      m_lat       = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 6));
      m_chk_legal = (force_legal >= 0) ? force_legal : int'($urandom % 2);
      w = t + 2 + m_lat;
      if (w < t + 3) w = t + 3;
      t_resp  = w + 1;
      m_legal = m_chk_legal;
`ifdef DECODER_TIMEOUT_EN
      if (w > t + 2 + TO_N) begin
        t_resp  = t + 3 + TO_N;
        m_legal = 0;
        m_err   = 3;
      end
`endif
    end else begin
      t_resp  = t + 2;
      m_legal = 0;
    end
    active   = 1'b1;
    cmp_dp   = 1'b0;
    cmp_resp = 1'b0;
  endtask

  task automatic project();
    exp_ready = !active;
    exp_start = active && m_ok && (cyc == t_acc + 2);
    exp_sel   = (active && m_ok && cyc >= t_acc + 2 && cyc < t_resp) ? m_sel : 6'd0;
    exp_rv    = active && (cyc >= t_resp);
    if (active && cyc >= t_acc + 2) begin
      cmp_dp = 1'b1; exp_piece = m_piece; exp_hd = m_hd; exp_vd = m_vd;
    end
    if (exp_rv) begin
      cmp_resp = 1'b1; exp_legal = m_legal; exp_err = m_err;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (reset) model_reset();
    else if (active && exp_rv && resp_ready) begin
      active = 1'b0; cmp_dp = 1'b0; cmp_resp = 1'b0;
    end else if (!active && req_valid) accept(cyc - 1);
    project();
  endtask

  task automatic drive_cycle();
    logic [5:0] nv, nm;
    int k;
    nv = 6'($urandom);
    nm = 6'($urandom);
    if (active && m_ok) begin
      k = m_kind - 1;
      nv[k] = (cyc >= t_acc + 2 + m_lat);
      if (nv[k]) nm[k] = m_chk_legal[0];
    end
    chk_valid_output = nv;
    chk_valid_move   = nm;
    if (rr_delay < 0) resp_ready = $urandom_range(0, 1) == 1;
    else resp_ready = exp_rv && (cyc >= t_resp + rr_delay);
    // board may change at any time except the cycle the decoder reads it
    if (scramble_en && !(active && cyc == t_acc + 1) && ($urandom % 4 == 0)) begin
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++)
          board_in[y][x] = 4'($urandom);
    end
  endtask

  task automatic clear_caps();
    cap_rv_seen = 1'b0; cap_rv_len = 0; cap_start = -1; cap_resp = -1;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while (active && guard < 100) begin step(); drive_cycle(); guard++; end
    if (active) check(name, 1, 0);
  endtask

  task automatic run_txn(input int ox, input int oy, input int nx, input int ny,
                         input int side, input int src_code, input int dst_code);
    wait_idle("pre_txn_idle_bound");
    clear_caps();
    old_x = 3'(ox); old_y = 3'(oy); new_x = 3'(nx); new_y = 3'(ny);
    side_to_move = side[0];
    if (src_code >= 0) board_in[oy][ox] = 4'(src_code);
    if (dst_code >= 0) board_in[ny][nx] = 4'(dst_code);
    req_valid = 1'b1;
    step(); drive_cycle();
    req_valid = 1'b0;
    wait_idle("txn_done_bound");
  endtask

  // single compare process
  always @(negedge clk) begin
    if (chk_start) begin
      n_starts++; cap_start = cyc; cap_sel = int'(chk_sel);
      cap_hd = int'(h_delta); cap_vd = int'(v_delta);
    end
    if (resp_valid) begin
      if (!cap_rv_seen) begin
        cap_rv_seen = 1'b1; cap_resp = cyc;
        cap_legal = int'(resp_legal); cap_err = int'(resp_err);
      end
      cap_rv_len++;
    end
    check("req_ready", int'(req_ready), int'(exp_ready));
    check("resp_valid", int'(resp_valid), int'(exp_rv));
    check("chk_start", int'(chk_start), int'(exp_start));
    check("chk_sel", int'(chk_sel), int'(exp_sel));
    if (cmp_dp) begin
      check("piece_type", int'(piece_type), exp_piece);
      check("h_delta", int'(h_delta), exp_hd);
      check("v_delta", int'(v_delta), exp_vd);
    end
    if (cmp_resp) begin
      check("resp_legal", int'(resp_legal), exp_legal);
      check("resp_err", int'(resp_err), exp_err);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts_before, side, kind, r;
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    old_x = '0; old_y = '0; new_x = '0; new_y = '0; side_to_move = 1'b0;
    board_in = '0; chk_valid_move = '0; chk_valid_output = '0;
    n_starts = 0;
    clear_caps();
    model_reset();
    project();

    step(); drive_cycle();
    check("reset_req_ready", int'(req_ready), 1);
    check("reset_resp_valid", int'(resp_valid), 0);
    step(); drive_cycle();
    reset = 1'b0;
    step(); drive_cycle();

    // white bishop (2,0) -> (5,3)
    board_in = '0; force_lat = 1; force_legal = 1; rr_delay = 0;
    run_txn(2, 0, 5, 3, 0, 3, 0);
    check("bishop_model_sel", int'(m_sel), 4);
    check("bishop_model_hd", m_hd, 3);
    check("bishop_start_ofs", cap_start - t_acc, 2);
    check("bishop_sel", cap_sel, 6'b000100);
    check("bishop_hd", cap_hd, 3);
    check("bishop_vd", cap_vd, 3);
    check("bishop_resp_ofs", cap_resp - t_acc, 4);
    check("bishop_legal", cap_legal, 1);
    check("bishop_err", cap_err, 0);

    // empty source
    starts_before = n_starts;
    run_txn(4, 4, 5, 5, 0, 0, -1);
    check("empty_model_err", m_err, 1);
    check("empty_resp_ofs", cap_resp - t_acc, 2);
    check("empty_legal", cap_legal, 0);
    check("empty_err", cap_err, 1);
    check("empty_no_start", n_starts - starts_before, 0);

    // rook onto own knight, null move
    board_in = '0;
    run_txn(0, 0, 0, 5, 0, 4, 2);
    check("own_capture_err", cap_err, 2);
    check("own_capture_resp_ofs", cap_resp - t_acc, 2);
    run_txn(3, 3, 3, 3, 0, 5, -1);
    check("null_move_err", cap_err, 2);

    // black rook with wrong and right side; checker result already valid on WAIT entry
    board_in = '0; force_lat = 0; force_legal = 0;
    run_txn(1, 1, 1, 4, 0, 12, 0);
    check("wrong_side_err", cap_err, 1);
    run_txn(1, 1, 1, 4, 1, 12, 0);
    check("black_rook_sel", cap_sel, 6'b001000);
    check("black_rook_vd", cap_vd, 3);
    check("black_rook_resp_ofs", cap_resp - t_acc, 4);
    check("black_rook_err", cap_err, 0);

    // response back-pressure for 5 cycles
    force_lat = 2; force_legal = 1; rr_delay = 5;
    run_txn(0, 0, 7, 7, 0, 5, 0);
    check("hold_resp_len", cap_rv_len, 6);
    check("hold_legal", cap_legal, 1);
    rr_delay = 0;

    // reset while waiting on a silent checker
    force_lat = 20;
    wait_idle("rst_pre_idle_bound");
    old_x = 3'd4; old_y = 3'd0; new_x = 3'd4; new_y = 3'd1; side_to_move = 1'b0;
    board_in[0][4] = 4'h6; board_in[1][4] = 4'h0;
    req_valid = 1'b1;
    step(); drive_cycle();
    req_valid = 1'b0;
    repeat (3) begin step(); drive_cycle(); end
    check("rst_in_wait_sel", int'(chk_sel), 6'b100000);
    reset = 1'b1;
    model_reset(); project();
    step(); drive_cycle();
    step(); drive_cycle();
    reset = 1'b0;
    step(); drive_cycle();
    check("rst_ready_after", int'(req_ready), 1);
    check("rst_sel_after", int'(chk_sel), 0);
    check("rst_resp_after", int'(resp_valid), 0);

`ifdef DECODER_TIMEOUT_EN
    force_lat = TO_N + 1; force_legal = 1;
    run_txn(2, 0, 5, 3, 0, 3, 0);
    check("timeout_err", cap_err, 3);
    check("timeout_legal", cap_legal, 0);
    check("timeout_resp_ofs", cap_resp - t_acc, 3 + TO_N);
    force_lat = TO_N;
    run_txn(2, 0, 5, 3, 0, 3, 0);
    check("limit_result_err", cap_err, 0);
    check("limit_result_legal", cap_legal, 1);
    check("limit_result_ofs", cap_resp - t_acc, 3 + TO_N);
`endif

    // randomized traffic
    force_lat = -1; force_legal = -1; rr_delay = -1; scramble_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      side = int'($urandom % 2);
      kind = int'($urandom_range(1, 6));
      r = int'($urandom % 4);
      run_txn(int'($urandom % 8), int'($urandom % 8), int'($urandom % 8), int'($urandom % 8), side,
              ($urandom % 10 < 6) ? side * 8 + kind : -1,
              (r == 0) ? 0 : (r == 1) ? side * 8 + kind : -1);
    end
    wait_idle("final_idle_bound");
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
